// File: rtl/aes_stream_core.sv
// aes_stream_core: iterative AES-128 encrypt/decrypt engine with BUS_W-wide
// beat-serial input and output streams and a stored 11-entry key schedule.
// Handshake: a beat transfers on a rising CLK edge where valid and ready are
// both high; the sender holds valid and its data stable until that edge,
// while ready may change freely from cycle to cycle.
module aes_stream_core #(
    parameter int BUS_W = 64
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    input  logic [BUS_W-1:0] in_key,
    input  logic             in_mode,
    input  logic             in_new_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             busy,
    output logic             key_ready,
    output logic [3:0]       round_cnt,
    output logic [2:0]       state_dbg
);
    localparam int BEATS = 128 / BUS_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KEXP, S_ARK, S_ROUND, S_UNLOAD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [3:0]        round_q, round_d;
    logic              mode_q, mode_d, nk_q, nk_d, kr_q, kr_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [BUS_W-1:0]  out_data_q, out_data_d;
    logic [127:0]      key_q, key_d, data_q, data_d;
    logic [127:0]      rk_q [11];
    logic [127:0]      rk_d [11];
    logic [127:0]      rnd;
    logic              nk_eff;

    // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // State byte n (column-major, n = 4*col + row) sits at bits [127-8n -: 8]
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = inv ? inv_sbox(s[127-8*n -: 8]) : sbox(s[127-8*n -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[(r+j)%4], m[j]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // Rcon for round key i: 01,02,04,...,80,1b,36
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < 11; k++)
            if (k < int'(i)) r = xtime(r);
        return r;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Beat idx of a 128-bit block, MSB-first
    function automatic logic [BUS_W-1:0] get_beat(input logic [127:0] v, input int idx);
        logic [127:0] t;
        t = v >> (128 - BUS_W * (idx + 1));
        return t[BUS_W-1:0];
    endfunction

    function automatic logic [127:0] put_beat(input logic [127:0] v, input int idx,
                                              input logic [BUS_W-1:0] d);
        logic [127:0] m;
        logic [127:0] dz;
        m  = '0;
        dz = '0;
        m[BUS_W-1:0]  = '1;
        dz[BUS_W-1:0] = d;
        return (v & ~(m << (128 - BUS_W * (idx + 1)))) | (dz << (128 - BUS_W * (idx + 1)));
    endfunction

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        round_d     = round_q;
        mode_d      = mode_q;
        nk_d        = nk_q;
        kr_d        = kr_q;
        key_d       = key_q;
        data_d      = data_q;
        rk_d        = rk_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rnd         = data_q;
        // mode/new_key come from the port on beat 0, from the latch afterwards
        nk_eff      = (state_q == S_IDLE) ? in_new_key : nk_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    if (state_q == S_IDLE) begin
                        mode_d = in_mode;
                        nk_d   = in_new_key;
                    end
                    data_d = put_beat(data_q, int'(beat_q), in_data);
                    if (nk_eff) key_d = put_beat(key_q, int'(beat_q), in_key);
                    if (beat_q == CW'(BEATS - 1)) begin
                        beat_d     = '0;
                        in_ready_d = 1'b0;
                        if (nk_eff || !kr_q) begin
                            state_d  = S_KEXP;
                            rk_d[0]  = key_d;
                            round_d  = 4'd1;
                            if (nk_eff) kr_d = 1'b0;
                        end else begin
                            state_d = S_ARK;
                        end
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_KEXP: begin
                rk_d[round_q] = key_step(rk_q[round_q - 4'd1], rcon(round_q));
                if (round_q == 4'd10) begin
                    state_d = S_ARK;
                    round_d = 4'd0;
                    kr_d    = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_ARK: begin
                data_d  = data_q ^ (mode_q ? rk_q[10] : rk_q[0]);
                state_d = S_ROUND;
                round_d = 4'd1;
            end
            S_ROUND: begin
                if (!mode_q) begin
                    rnd = shift_rows(sub_bytes(data_q, 1'b0), 1'b0);
                    if (round_q != 4'd10) rnd = mix_cols(rnd, 1'b0);
                    rnd = rnd ^ rk_q[round_q];
                end else begin
                    rnd = sub_bytes(shift_rows(data_q, 1'b1), 1'b1);
                    rnd = rnd ^ rk_q[4'd10 - round_q];
                    if (round_q != 4'd10) rnd = mix_cols(rnd, 1'b1);
                end
                data_d = rnd;
                if (round_q == 4'd10) begin
                    state_d     = S_UNLOAD;
                    round_d     = 4'd0;
                    beat_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = get_beat(rnd, 0);
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (beat_q == CW'(BEATS - 1)) begin
                        state_d     = S_IDLE;
                        beat_d      = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        in_ready_d  = 1'b1;
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        out_data_d = get_beat(data_q, int'(beat_q) + 1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts everything and drops the schedule
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            round_q     <= 4'd0;
            mode_q      <= 1'b0;
            nk_q        <= 1'b0;
            kr_q        <= 1'b0;
            key_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            round_q     <= round_d;
            mode_q      <= mode_d;
            nk_q        <= nk_d;
            kr_q        <= kr_d;
            key_q       <= key_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rk_q        <= rk_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    assign key_ready = kr_q;
    assign round_cnt = round_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_stream_core.sv
// tb_aes_stream_core: directed FIPS-197 vectors through 32/64/128-bit instances.
module tb_aes_stream_core;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CTZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] JUNK = {128{1'b1}};

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic iv32, ir32, im32, ink32, ov32, ord32, busy32, kr32;
    logic [31:0] id32, ik32, od32;
    logic [3:0]  rc32;
    logic [2:0]  sd32;
    logic iv64, ir64, im64, ink64, ov64, ord64, busy64, kr64;
    logic [63:0] id64, ik64, od64;
    logic [3:0]  rc64;
    logic [2:0]  sd64;
    logic iv128, ir128, im128, ink128, ov128, ord128, busy128, kr128;
    logic [127:0] id128, ik128, od128;
    logic [3:0]   rc128;
    logic [2:0]   sd128;

    // Clock
    always #5 clk = ~clk;

    aes_stream_core #(.BUS_W(32)) u32 (
        .CLK(clk), .reset(rst_n), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
        .in_key(ik32), .in_mode(im32), .in_new_key(ink32), .out_valid(ov32),
        .out_ready(ord32), .out_data(od32), .busy(busy32), .key_ready(kr32),
        .round_cnt(rc32), .state_dbg(sd32));

    aes_stream_core #(.BUS_W(64)) u64 (
        .CLK(clk), .reset(rst_n), .in_valid(iv64), .in_ready(ir64), .in_data(id64),
        .in_key(ik64), .in_mode(im64), .in_new_key(ink64), .out_valid(ov64),
        .out_ready(ord64), .out_data(od64), .busy(busy64), .key_ready(kr64),
        .round_cnt(rc64), .state_dbg(sd64));

    aes_stream_core #(.BUS_W(128)) u128 (
        .CLK(clk), .reset(rst_n), .in_valid(iv128), .in_ready(ir128), .in_data(id128),
        .in_key(ik128), .in_mode(im128), .in_new_key(ink128), .out_valid(ov128),
        .out_ready(ord128), .out_data(od128), .busy(busy128), .key_ready(kr128),
        .round_cnt(rc128), .state_dbg(sd128));

    // Per-width accessors
    function automatic logic get_ir(input int w);
        case (w) 32: return ir32; 64: return ir64; default: return ir128; endcase
    endfunction
    function automatic logic get_ov(input int w);
        case (w) 32: return ov32; 64: return ov64; default: return ov128; endcase
    endfunction
    function automatic logic get_busy(input int w);
        case (w) 32: return busy32; 64: return busy64; default: return busy128; endcase
    endfunction
    function automatic logic get_kr(input int w);
        case (w) 32: return kr32; 64: return kr64; default: return kr128; endcase
    endfunction
    function automatic logic [3:0] get_rc(input int w);
        case (w) 32: return rc32; 64: return rc64; default: return rc128; endcase
    endfunction
    function automatic logic [2:0] get_sd(input int w);
        case (w) 32: return sd32; 64: return sd64; default: return sd128; endcase
    endfunction
    function automatic logic [127:0] get_od(input int w);
        case (w) 32: return 128'(od32); 64: return 128'(od64); default: return od128; endcase
    endfunction

    // Beat k of a block for width w, MSB-first, zero-extended
    function automatic logic [127:0] beat_of(input int w, input logic [127:0] v, input int k);
        logic [127:0] t;
        logic [127:0] m;
        t = v >> (128 - w * (k + 1));
        m = (128'd1 << w) - 128'd1;
        return t & m;
    endfunction

    // Scoreboard comparison
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_in(input int w, input logic v, input logic [127:0] d,
                            input logic [127:0] k, input logic m, input logic nk);
        case (w)
            32: begin iv32 = v; id32 = d[31:0]; ik32 = k[31:0]; im32 = m; ink32 = nk; end
            64: begin iv64 = v; id64 = d[63:0]; ik64 = k[63:0]; im64 = m; ink64 = nk; end
            default: begin iv128 = v; id128 = d; ik128 = k; im128 = m; ink128 = nk; end
        endcase
    endtask

    task automatic set_ord(input int w, input logic r);
        case (w) 32: ord32 = r; 64: ord64 = r; default: ord128 = r; endcase
    endtask

    // Sends one block; later beats carry inverted mode/new_key which must be ignored
    task automatic send_block(input int w, input logic [127:0] key, input logic [127:0] pt,
                              input logic m, input logic nk, input int gap);
        int nb;
        int guard;
        nb = 128 / w;
        for (int k = 0; k < nb; k++) begin
            drive_in(w, 1'b1, beat_of(w, pt, k), beat_of(w, key, k),
                     (k == 0) ? m : ~m, (k == 0) ? nk : ~nk);
            guard = 0;
            while (!get_ir(w) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("in_ready_timeout", 128'(get_ir(w)), 128'd1);
            @(posedge clk);
            @(negedge clk);
            if (gap > 0 && k < nb - 1) begin
                drive_in(w, 1'b0, '0, '0, 1'b0, 1'b0);
                repeat (gap) @(negedge clk);
                chk("in_ready_gap", 128'(get_ir(w)), 128'd1);
            end
        end
        drive_in(w, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Counts negedges from the last-beat acceptance edge until out_valid
    task automatic wait_out(input int w, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        chk({tag, "_in_ready_low"}, 128'(get_ir(w)), 128'd0);
        chk({tag, "_busy"}, 128'(get_busy(w)), 128'd1);
        while (!get_ov(w) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    endtask

    task automatic recv_block(input int w, input logic [127:0] exp, input int stall_at,
                              input string tag);
        int nb;
        nb = 128 / w;
        for (int k = 0; k < nb; k++) begin
            if (k == stall_at) begin
                set_ord(w, 1'b0);
                repeat (5) begin
                    @(negedge clk);
                    chk({tag, "_stall_valid"}, 128'(get_ov(w)), 128'd1);
                    chk({tag, "_stall_data"}, get_od(w), beat_of(w, exp, k));
                end
            end
            set_ord(w, 1'b1);
            chk($sformatf("%s_beat%0d", tag, k), get_od(w), beat_of(w, exp, k));
            @(posedge clk);
            @(negedge clk);
        end
        set_ord(w, 1'b0);
        chk({tag, "_done_valid"}, 128'(get_ov(w)), 128'd0);
        chk({tag, "_done_busy"}, 128'(get_busy(w)), 128'd0);
    endtask

    task automatic check_reset_state(input int w, input string tag);
        chk({tag, "_in_ready"}, 128'(get_ir(w)), 128'd1);
        chk({tag, "_out_valid"}, 128'(get_ov(w)), 128'd0);
        chk({tag, "_out_data"}, get_od(w), 128'd0);
        chk({tag, "_busy"}, 128'(get_busy(w)), 128'd0);
        chk({tag, "_key_ready"}, 128'(get_kr(w)), 128'd0);
        chk({tag, "_round_cnt"}, 128'(get_rc(w)), 128'd0);
        chk({tag, "_state"}, 128'(get_sd(w)), 128'd0);
    endtask

    // Directed sequence
    initial begin
        int guard;
        rst_n = 1'b0;
        drive_in(32, 1'b0, '0, '0, 1'b0, 1'b0);
        drive_in(64, 1'b0, '0, '0, 1'b0, 1'b0);
        drive_in(128, 1'b0, '0, '0, 1'b0, 1'b0);
        set_ord(32, 1'b0);
        set_ord(64, 1'b0);
        set_ord(128, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_state(32, "rst32");
        check_reset_state(64, "rst64");
        check_reset_state(128, "rst128");
        rst_n = 1'b1;
        @(negedge clk);

        // Post-reset block without new key: zero key is expanded
        send_block(64, JUNK, 128'd0, 1'b0, 1'b0, 0);
        wait_out(64, 21, "zero_key");
        recv_block(64, CTZ, -1, "zero_key");
        chk("zero_key_key_ready", 128'(kr64), 128'd1);

        // FIPS-197 C.1 encrypt with new key
        send_block(64, K1, P1, 1'b0, 1'b1, 0);
        wait_out(64, 21, "c1_enc");
        recv_block(64, CT1, -1, "c1_enc");
        chk("c1_enc_key_ready", 128'(kr64), 128'd1);

        // Decrypt under the stored schedule; key beats must be discarded
        send_block(64, JUNK, CT1, 1'b1, 1'b0, 0);
        wait_out(64, 11, "c1_dec");
        chk("c1_dec_key_ready_mid", 128'(kr64), 128'd1);
        recv_block(64, P1, -1, "c1_dec");
        chk("c1_dec_key_ready", 128'(kr64), 128'd1);

        // Input gaps and output stall
        send_block(64, JUNK, P1, 1'b0, 1'b0, 3);
        wait_out(64, 11, "bp");
        recv_block(64, CT1, 1, "bp");

        // FIPS-197 B at 32 and 128 bits
        send_block(32, K2, P2, 1'b0, 1'b1, 0);
        wait_out(32, 21, "b_w32");
        recv_block(32, CT2, 2, "b_w32");
        send_block(128, K2, P2, 1'b0, 1'b1, 0);
        wait_out(128, 21, "b_w128");
        recv_block(128, CT2, -1, "b_w128");

        // Reset in the middle of round 5
        send_block(64, JUNK, P1, 1'b0, 1'b0, 0);
        guard = 0;
        while (rc64 != 4'd5 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_round5_reached", 128'(rc64), 128'd5);
        rst_n = 1'b0;
        #1;
        check_reset_state(64, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_block(64, K1, P1, 1'b0, 1'b1, 0);
        wait_out(64, 21, "after_abort");
        recv_block(64, CT1, -1, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
